fetch_ctrl: RTL

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_wdog.sv | 31 +++
 rtl/fetch_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StHold,
        StFault
    } fetch_state_e;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam int unsigned MAX_WAIT_DEFAULT = 16;

endpackage

// File: rtl/fetch_wdog.sv
// Request watchdog: counts cycles a fetch request waits without an acknowledge.
module fetch_wdog
    import fetch_pkg::*;
#(
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic CLK,
    input  logic RST,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CntW = $clog2(MAX_WAIT + 1);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Fires during the MAX_WAIT-th unacknowledged cycle so the fault follows it directly.
    assign expired = enable && (cnt_q >= CntW'(MAX_WAIT - 1));

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: single outstanding request, one-entry output buffer,
// redirect handling with squash of in-flight requests, and sticky timeout/misalign fault.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned MAX_WAIT     = MAX_WAIT_DEFAULT
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        redirect_jalr,
    output logic [31:0] pc,
    output logic        fault,
    output logic [31:0] fetch_count
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  inst_q, inst_d;
    logic [31:0]  inst_pc_q, inst_pc_d;
    logic         valid_q, valid_d;
    logic [31:0]  count_q, count_d;
    logic         squash_q, squash_d;
    logic [31:0]  sq_tgt_q, sq_tgt_d;
    logic [31:0]  eff_tgt;
    logic         wd_expired;

    assign eff_tgt = redirect_jalr ? {redirect_target[31:1], 1'b0} : redirect_target;

    fetch_wdog #(
        .MAX_WAIT(MAX_WAIT)
    ) u_wdog (
        .CLK    (CLK),
        .RST    (RST),
        .clear  ((state_q != StReq) || imem_ack),
        .enable ((state_q == StReq) && !imem_ack),
        .expired(wd_expired)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        valid_d   = valid_q;
        count_d   = count_q;
        squash_d  = squash_q;
        sq_tgt_d  = sq_tgt_q;
        unique case (state_q)
            StIdle: begin
                state_d = StReq;
                if (redirect_valid) begin
                    if (eff_tgt[1]) state_d = StFault;
                    else pc_d = eff_tgt;
                end
            end
            StReq: begin
                if (redirect_valid && eff_tgt[1]) begin
                    state_d = StFault;
                end else if (imem_ack) begin
                    squash_d = 1'b0;
                    if (redirect_valid) begin
                        pc_d = eff_tgt;
                    end else if (squash_q) begin
                        pc_d = sq_tgt_q;
                    end else begin
                        inst_d    = imem_rdata;
                        inst_pc_d = pc_q;
                        valid_d   = 1'b1;
                        pc_d      = pc_q + 32'd4;
                        state_d   = StHold;
                    end
                end else begin
                    // Request stays at the old address; remember where to go once it lands.
                    if (redirect_valid) begin
                        squash_d = 1'b1;
                        sq_tgt_d = eff_tgt;
                    end
                    if (wd_expired) state_d = StFault;
                end
            end
            StHold: begin
                if (inst_ready) begin
                    count_d = count_q + 32'd1;
                    valid_d = 1'b0;
                    state_d = StReq;
                end
                if (redirect_valid) begin
                    valid_d = 1'b0;
                    if (eff_tgt[1]) begin
                        state_d = StFault;
                    end else begin
                        pc_d    = eff_tgt;
                        state_d = StReq;
                    end
                end
            end
            StFault: begin
            end
            default: state_d = StFault;
        endcase
        if (state_d == StFault) begin
            valid_d  = 1'b0;
            squash_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= StIdle;
            pc_q      <= RESET_VECTOR;
            inst_q    <= NOP_INST;
            inst_pc_q <= RESET_VECTOR;
            valid_q   <= 1'b0;
            count_q   <= 32'd0;
            squash_q  <= 1'b0;
            sq_tgt_q  <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            valid_q   <= valid_d;
            count_q   <= count_d;
            squash_q  <= squash_d;
            sq_tgt_q  <= sq_tgt_d;
        end
    end

    assign imem_req    = (state_q == StReq);
    assign imem_addr   = pc_q;
    assign inst_valid  = valid_q;
    assign inst        = inst_q;
    assign inst_pc     = inst_pc_q;
    assign pc          = pc_q;
    assign fault       = (state_q == StFault);
    assign fetch_count = count_q;

endmodule
